// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int PC_INCR = 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instructions tagged with their PC.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the PC register, issues imem reads, buffers results.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_W,
  parameter int                    INSTR_WIDTH = INSTR_W,
  parameter int                    DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ADDR_WIDTH-1:0]  pc_q,
  output logic                   pc_en,
  output logic [ADDR_WIDTH-1:0]  pc_d,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  pop;
  logic                  push;
  logic                  issue;
  fetch_entry_t          din;
  fetch_entry_t          head;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect_valid;

  // Slots already claimed once this cycle's pop retires.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = resetn & ~redirect_valid & (occ < (CW+1)'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  always_comb begin
    pc_en = 1'b0;
    pc_d  = pc_q;
    unique case (1'b1)
      !resetn: begin
        pc_en = 1'b1;
        pc_d  = RESET_PC;
      end
      redirect_valid: begin
        pc_en = 1'b1;
        pc_d  = redirect_addr;
      end
      issue: begin
        pc_en = 1'b1;
        pc_d  = pc_q + ADDR_WIDTH'(PC_INCR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc_q;
    end
  end

  assign din.instr = imem_rdata;
  assign din.pc    = inflight_pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .din    (din),
    .head   (head),
    .count  (count)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register and imem model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  pc_q;
  logic        pc_en;
  logic [7:0]  pc_d;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .pc_q           (pc_q),
    .pc_en          (pc_en),
    .pc_d           (pc_d),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always @(posedge clk) begin
    if (pc_en) pc_q <= pc_d;
  end

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 16'h0100 + {8'h00, imem_addr};
    else          imem_rdata <= 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consume n instructions in order from exp_pc; lat = cycles to first.
  task automatic drain(input int n, input int lat);
    int got = 0;
    int cyc = 0;
    int first = -1;
    while (got < n && cyc < 40) begin
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        check("out_pc", out_pc, exp_pc);
        check("out_instr", out_instr, 16'h0100 + {8'h00, exp_pc});
        exp_pc = exp_pc + 8'd1;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_count", got, n);
    check("latency", first, lat);
  endtask

  task automatic redirect(input logic [7:0] addr);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    out_ready      = 1'b0;
    #1;
    check("redir_pc_en", pc_en, 1'b1);
    check("redir_pc_d", pc_d, addr);
    check("redir_req", imem_req, 1'b0);
    @(negedge clk);
    check("redir_flush", out_valid, 1'b0);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    exp_pc         = addr;
    drain(4, 2);
  endtask

  initial begin
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'h00;
    out_ready      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pc_en", pc_en, 1'b1);
    check("rst_pc_d", pc_d, 8'h00);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", out_valid, 1'b0);

    resetn = 1'b1;
    #1;
    check("rel_req", imem_req, 1'b1);
    check("rel_addr", imem_addr, 8'h00);
    exp_pc = 8'h00;
    drain(4, 2);

    out_ready = 1'b0;
    @(negedge clk);
    check("bp_req", imem_req, 1'b0);
    check("bp_pc_en", pc_en, 1'b0);
    check("bp_valid", out_valid, 1'b1);
    check("bp_pc", out_pc, 8'h04);
    check("bp_instr", out_instr, 16'h0104);
    @(negedge clk);
    check("bp_hold_pc", out_pc, 8'h04);
    check("bp_hold_instr", out_instr, 16'h0104);
    check("bp_hold_req", imem_req, 1'b0);
    out_ready = 1'b1;
    drain(6, 0);

    redirect(8'h40);
    redirect(8'hFE);

    resetn = 1'b0;
    #1;
    check("mrst_pc_en", pc_en, 1'b1);
    check("mrst_pc_d", pc_d, 8'h00);
    check("mrst_req", imem_req, 1'b0);
    @(negedge clk);
    check("mrst_valid", out_valid, 1'b0);
    @(negedge clk);
    check("mrst_valid2", out_valid, 1'b0);
    resetn = 1'b1;
    #1;
    check("mrst_req_rel", imem_req, 1'b1);
    check("mrst_addr", imem_addr, 8'h00);
    exp_pc = 8'h00;
    drain(4, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
